// File: rtl/sync_tx_scheduler.sv
// Round-robin source sequencer for the strobe-qualified data synchronizer.
// Each granted word is held on sync_data while sync_stb is high and while the receiver drains its control chain.
module sync_tx_scheduler #(
    parameter int N    = 8,
    parameter int NREQ = 4,
    parameter int HOLD = 3,
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ena,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*N-1:0]    req_data,
    output logic [NREQ-1:0]      gnt,
    output logic [N-1:0]         sync_data,
    output logic                 sync_stb,
    output logic                 busy,
    output logic [IDW-1:0]       last_id
);

    localparam int CW = $clog2(HOLD + 1);
    localparam logic [IDW-1:0] LAST_RST = IDW'(NREQ - 1);
    localparam logic [CW-1:0]  CNT_LOAD = CW'(HOLD - 1);

    typedef enum logic [1:0] {IDLE, ASSERT, DRAIN} state_t;

    state_t            state_reg, state_next;
    logic [CW-1:0]     cnt_reg, cnt_next;
    logic [N-1:0]      data_reg, data_next;
    logic [IDW-1:0]    last_reg, last_next;
    logic [NREQ-1:0]   gnt_reg, gnt_next;
    logic              stb_reg;
    logic              busy_reg;

    logic [N-1:0]      words    [NREQ];
    logic [IDW-1:0]    cand_idx [NREQ];
    logic [IDW-1:0]    winner;
    logic              found;

    // cand_idx[k] is the k-th requester in priority order, starting just after the last winner
    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_slot
            assign words[gi]    = req_data[gi*N +: N];
            assign cand_idx[gi] = IDW'((int'(last_reg) + gi + 1) % NREQ);
        end
    endgenerate

    always_comb begin : pick_winner
        winner = '0;
        found  = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (!found && req[cand_idx[k]]) begin
                winner = cand_idx[k];
                found  = 1'b1;
            end
        end
    end

    always_comb begin : next_state
        state_next = state_reg;
        cnt_next   = cnt_reg;
        data_next  = data_reg;
        last_next  = last_reg;
        gnt_next   = '0;
        case (state_reg)
            IDLE: begin
                if (found) begin
                    state_next = ASSERT;
                    cnt_next   = CNT_LOAD;
                    data_next  = words[winner];
                    last_next  = winner;
                    gnt_next   = NREQ'(1) << winner;
                end
            end
            ASSERT: begin
                if (cnt_reg == '0) begin
                    state_next = DRAIN;
                    cnt_next   = CW'(1);
                end else begin
                    cnt_next = cnt_reg - CW'(1);
                end
            end
            DRAIN: begin
                // data must stay put here: the receiver still loads it for two more cycles
                if (cnt_reg == '0) begin
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt_reg - CW'(1);
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            data_reg  <= '0;
            last_reg  <= LAST_RST;
            gnt_reg   <= '0;
            stb_reg   <= 1'b0;
            busy_reg  <= 1'b0;
        end else if (ena) begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            data_reg  <= data_next;
            last_reg  <= last_next;
            gnt_reg   <= gnt_next;
            stb_reg   <= (state_next == ASSERT);
            busy_reg  <= (state_next != IDLE);
        end else begin
            // frozen: everything holds except the grant pulse, which must not repeat
            gnt_reg <= '0;
        end
    end

    assign gnt       = gnt_reg;
    assign sync_data = data_reg;
    assign sync_stb  = stb_reg;
    assign busy      = busy_reg;
    assign last_id   = last_reg;

endmodule

// File: tb/tb_sync_tx_scheduler.sv
// Self-checking bench for sync_tx_scheduler: directed vector table, hand-written corner sequences,
// and randomized traffic against a transfer-timeline reference model.
module tb_sync_tx_scheduler;

    localparam int N    = 8;
    localparam int NREQ = 4;
    localparam int HOLD = 3;
    localparam int IDW  = 2;
    localparam logic [NREQ*N-1:0] WORDS = {8'h3C, 8'hA5, 8'h5A, 8'h11};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // main instance (defaults)
    logic                rst = 1'b1;
    logic                ena = 1'b1;
    logic [NREQ-1:0]     req = '0;
    logic [NREQ*N-1:0]   req_data = WORDS;
    logic [NREQ-1:0]     gnt;
    logic [N-1:0]        sync_data;
    logic                sync_stb;
    logic                busy;
    logic [IDW-1:0]      last_id;

    // corner instance: HOLD=1, NREQ=2
    logic                b_rst = 1'b1;
    logic                b_ena = 1'b1;
    logic [1:0]          b_req = '0;
    logic [15:0]         b_req_data = {8'hB1, 8'hB0};
    logic [1:0]          b_gnt;
    logic [7:0]          b_sync_data;
    logic                b_sync_stb;
    logic                b_busy;
    logic [0:0]          b_last_id;

    sync_tx_scheduler #(.N(N), .NREQ(NREQ), .HOLD(HOLD)) dut (
        .clk(clk), .rst(rst), .ena(ena), .req(req), .req_data(req_data),
        .gnt(gnt), .sync_data(sync_data), .sync_stb(sync_stb), .busy(busy), .last_id(last_id)
    );

    sync_tx_scheduler #(.N(8), .NREQ(2), .HOLD(1)) dut_b (
        .clk(clk), .rst(b_rst), .ena(b_ena), .req(b_req), .req_data(b_req_data),
        .gnt(b_gnt), .sync_data(b_sync_data), .sync_stb(b_sync_stb), .busy(b_busy), .last_id(b_last_id)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int stb_cnt = 0;

    // reference model: a transfer is a timeline t = 0 .. HOLD+1 cycles since its grant
    bit              m_active = 1'b0;
    int              m_t      = 0;
    int              m_last   = NREQ - 1;
    logic [N-1:0]    m_data   = '0;
    logic [NREQ-1:0] m_gnt    = '0;

    int           g_id[$];
    int           g_cyc[$];
    logic [N-1:0] g_data[$];

    typedef struct packed {
        logic            rst;
        logic            ena;
        logic [NREQ-1:0] req;
        logic [NREQ-1:0] gnt;
        logic [N-1:0]    data;
        logic            stb;
        logic            busy;
        logic [IDW-1:0]  last;
    } vec_t;

    vec_t tbl [18];

    function automatic logic [N-1:0] word_of(input logic [NREQ*N-1:0] v, input int i);
        return v[i*N +: N];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_step();
        int w;
        m_gnt = '0;
        if (rst) begin
            m_active = 1'b0;
            m_t      = 0;
            m_last   = NREQ - 1;
            m_data   = '0;
        end else if (ena) begin
            if (!m_active) begin
                w = -1;
                for (int k = 1; k <= NREQ; k++) begin
                    if (w < 0 && req[(m_last + k) % NREQ]) w = (m_last + k) % NREQ;
                end
                if (w >= 0) begin
                    m_last   = w;
                    m_data   = word_of(req_data, w);
                    m_gnt[w] = 1'b1;
                    m_active = 1'b1;
                    m_t      = 0;
                end
            end else begin
                m_t++;
                if (m_t == HOLD + 2) m_active = 1'b0;
            end
        end
    endtask

    function automatic logic [15:0] dut_vec();
        return {gnt, sync_data, sync_stb, busy, last_id};
    endfunction

    task automatic cycle();
        logic exp_stb;
        @(posedge clk);
        model_step();
        cyc++;
        @(negedge clk);
        exp_stb = m_active && (m_t < HOLD);
        check("model", 32'(dut_vec()), 32'({m_gnt, m_data, exp_stb, m_active, IDW'(m_last)}));
        if (sync_stb) stb_cnt++;
        if (gnt != '0) begin
            g_id.push_back($clog2(int'(gnt)));
            g_cyc.push_back(cyc);
            g_data.push_back(sync_data);
            $display("[TB] grant id=%0d data=%h cycle=%0d", $clog2(int'(gnt)), sync_data, cyc);
        end
    endtask

    initial begin
        logic [7:0] rise_data;
        int         since_rise;
        logic       prev_stb;
        logic [1:0] exp_bg;

        // directed table: reset, single transfer with re-request, withdraw, rr, rst-over-ena, ena gnt gating
        tbl[0]  = '{1'b1, 1'b1, 4'hF, 4'h0, 8'h00, 1'b0, 1'b0, 2'd3};
        tbl[1]  = '{1'b1, 1'b1, 4'h5, 4'h0, 8'h00, 1'b0, 1'b0, 2'd3};
        tbl[2]  = '{1'b0, 1'b1, 4'h4, 4'h4, 8'hA5, 1'b1, 1'b1, 2'd2};
        tbl[3]  = '{1'b0, 1'b1, 4'h4, 4'h0, 8'hA5, 1'b1, 1'b1, 2'd2};
        tbl[4]  = '{1'b0, 1'b1, 4'h4, 4'h0, 8'hA5, 1'b1, 1'b1, 2'd2};
        tbl[5]  = '{1'b0, 1'b1, 4'h4, 4'h0, 8'hA5, 1'b0, 1'b1, 2'd2};
        tbl[6]  = '{1'b0, 1'b1, 4'h4, 4'h0, 8'hA5, 1'b0, 1'b1, 2'd2};
        tbl[7]  = '{1'b0, 1'b1, 4'h4, 4'h0, 8'hA5, 1'b0, 1'b0, 2'd2};
        tbl[8]  = '{1'b0, 1'b1, 4'h4, 4'h4, 8'hA5, 1'b1, 1'b1, 2'd2};
        tbl[9]  = '{1'b0, 1'b1, 4'h0, 4'h0, 8'hA5, 1'b1, 1'b1, 2'd2};
        tbl[10] = '{1'b0, 1'b1, 4'h0, 4'h0, 8'hA5, 1'b1, 1'b1, 2'd2};
        tbl[11] = '{1'b0, 1'b1, 4'h0, 4'h0, 8'hA5, 1'b0, 1'b1, 2'd2};
        tbl[12] = '{1'b0, 1'b1, 4'h0, 4'h0, 8'hA5, 1'b0, 1'b1, 2'd2};
        tbl[13] = '{1'b0, 1'b1, 4'h0, 4'h0, 8'hA5, 1'b0, 1'b0, 2'd2};
        tbl[14] = '{1'b0, 1'b1, 4'hF, 4'h8, 8'h3C, 1'b1, 1'b1, 2'd3};
        tbl[15] = '{1'b1, 1'b0, 4'hF, 4'h0, 8'h00, 1'b0, 1'b0, 2'd3};
        tbl[16] = '{1'b0, 1'b1, 4'hF, 4'h1, 8'h11, 1'b1, 1'b1, 2'd0};
        tbl[17] = '{1'b0, 1'b0, 4'hF, 4'h0, 8'h11, 1'b1, 1'b1, 2'd0};

        for (int i = 0; i < 18; i++) begin
            rst = tbl[i].rst;
            ena = tbl[i].ena;
            req = tbl[i].req;
            cycle();
            check($sformatf("vec%0d", i), 32'(dut_vec()),
                  32'({tbl[i].gnt, tbl[i].data, tbl[i].stb, tbl[i].busy, tbl[i].last}));
        end

        // round-robin with all requesters, then 4'b1010 with last_id=1
        rst = 1'b1; ena = 1'b1; req = '0;
        cycle();
        rst = 1'b0; req = 4'hF;
        g_id.delete(); g_cyc.delete(); g_data.delete();
        for (int i = 0; i < 36; i++) cycle();
        check("rr_count", 32'(g_id.size()), 32'd6);
        for (int i = 0; i < 6; i++) begin
            if (g_id.size() > i) begin
                check($sformatf("rr_id%0d", i), 32'(g_id[i]), 32'(i % 4));
                check($sformatf("rr_data%0d", i), 32'(g_data[i]), 32'(word_of(WORDS, i % 4)));
                if (i > 0) check($sformatf("rr_gap%0d", i), 32'(g_cyc[i] - g_cyc[i-1]), 32'd6);
            end
        end
        check("rr_last", 32'(last_id), 32'd1);
        req = 4'b1010;
        for (int i = 0; i < 12; i++) cycle();
        check("rr1010_count", 32'(g_id.size()), 32'd8);
        if (g_id.size() >= 8) begin
            check("rr1010_first", 32'(g_id[6]), 32'd3);
            check("rr1010_second", 32'(g_id[7]), 32'd1);
        end

        // enable freeze in the 2nd ASSERT cycle
        rst = 1'b1; req = '0;
        cycle();
        rst = 1'b0; req = 4'b0001;
        g_id.delete(); g_cyc.delete(); g_data.delete();
        stb_cnt = 0;
        cycle();
        req = '0;
        cycle();
        ena = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cycle();
            check("frz_stb", 32'(sync_stb), 32'd1);
            check("frz_data", 32'(sync_data), 32'h11);
        end
        ena = 1'b1;
        for (int i = 0; i < 6; i++) cycle();
        check("frz_stb_total", 32'(stb_cnt), 32'd7);
        check("frz_gnt_count", 32'(g_id.size()), 32'd1);
        check("frz_idle", 32'({sync_stb, busy}), 32'd0);

        // reset in DRAIN abandons the word; rearbitration starts at requester 0
        req = 4'b0100;
        cycle();
        req = '0;
        for (int i = 0; i < 3; i++) cycle();
        check("pre_rst_drain", 32'({sync_stb, busy}), 32'b01);
        rst = 1'b1;
        cycle();
        check("rst_mid", 32'(dut_vec()), 32'({4'h0, 8'h00, 1'b0, 1'b0, 2'd3}));
        rst = 1'b0; req = 4'hF;
        cycle();
        check("rst_regrant", 32'(gnt), 32'b0001);

        // randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 49) == 0);
            ena = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 3) == 0) req = 4'($urandom);
            req_data = $urandom;
            cycle();
        end

        // HOLD=1, NREQ=2 corner
        b_rst = 1'b1; b_req = 2'b11;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("b_reset", 32'({b_gnt, b_sync_data, b_sync_stb, b_busy, b_last_id}), 32'({2'b00, 8'h00, 1'b0, 1'b0, 1'b1}));
        b_rst = 1'b0;
        prev_stb = 1'b0;
        rise_data = '0;
        since_rise = 99;
        for (int it = 0; it < 20; it++) begin
            @(posedge clk);
            @(negedge clk);
            exp_bg = (it % 4 != 0) ? 2'b00 : (((it / 4) % 2 == 0) ? 2'b01 : 2'b10);
            check($sformatf("b_gnt%0d", it), 32'(b_gnt), 32'(exp_bg));
            check($sformatf("b_stb%0d", it), 32'(b_sync_stb), 32'(it % 4 == 0));
            if (b_gnt != 2'b00) begin
                $display("[TB] corner grant id=%0d data=%h iter=%0d", b_gnt[1], b_sync_data, it);
                check("b_word", 32'(b_sync_data), 32'(b_gnt[1] ? 8'hB1 : 8'hB0));
            end
            if (b_sync_stb && !prev_stb) begin
                rise_data = b_sync_data;
                since_rise = 0;
            end else begin
                since_rise++;
            end
            if (since_rise > 0 && since_rise < 3)
                check("b_hold", 32'(b_sync_data), 32'(rise_data));
            prev_stb = b_sync_stb;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
